inst_fetch_buf: RTL
===================

INST_FETCH_BUF -- requirements
Module: inst_fetch_buf

Interface
REQ-001 SHALL have port clk  in  1  clock; all state changes on rising edge.
REQ-002 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have port pc_i  in  32  fetch address from PC register.
REQ-004 SHALL have port ce_i  in  1  PC register chip enable; 0 means no fetch is wanted.
REQ-005 SHALL have port stall  in  6  pipeline stall vector; stall[1]=1 holds the ID-side outputs.
REQ-006 SHALL have port flush  in  1  discard all buffered and in-flight instructions.
REQ-007 SHALL have port mem_req  out  1  instruction memory request, held until acknowledged.
REQ-008 SHALL have port mem_addr  out  32  request address, stable while mem_req=1.
REQ-009 SHALL have port mem_ack  in  1  memory response; mem_rdata is valid in the same cycle; ack may coincide with the first mem_req cycle.
REQ-010 SHALL have port mem_rdata  in  32  instruction word.
REQ-011 SHALL have port id_pc  out  32  registered PC to ID stage.
REQ-012 SHALL have port id_inst  out  32  registered instruction to ID stage.
REQ-013 SHALL have port id_valid  out  1  id_pc and id_inst hold a real instruction.
REQ-014 SHALL have port fetch_stall_req  out  1  combinational request to the control unit to freeze the PC (drives stall[0]).

Function
REQ-015 SHALL implement an FSM with three states: IDLE (nothing outstanding), WAIT (request outstanding), and DROP (outstanding request whose data is discarded).
REQ-016 SHALL accept pc_i in a cycle when all of the following hold: ce_i=1; flush=0; no request remains outstanding after this cycle (IDLE, or WAIT with mem_ack=1); and FIFO occupancy after this cycle's push/pop is at most 1.
REQ-017 SHALL, on accept, latch pc_i into mem_addr, assert mem_req from the next cycle, and enter WAIT.
REQ-018 SHALL drive fetch_stall_req = ce_i & ~flush & ~accept.
REQ-019 SHALL, in WAIT with mem_ack=1, push {mem_addr, mem_rdata} into a 2-entry FIFO, then deassert mem_req unless a new accept occurs in the same cycle.
REQ-020 SHALL, on each edge with stall[1]=0 and flush=0, pop the FIFO head into id_pc/id_inst with id_valid=1; if the FIFO is empty, load a bubble (id_inst=0, id_valid=0, id_pc held).
REQ-021 SHALL hold id_pc, id_inst and id_valid, and perform no pop, while stall[1]=1.
REQ-022 SHALL allow a simultaneous push and pop on a full FIFO only as a pop followed by a push, with no loss and no overflow.
REQ-023 SHALL, on flush=1, empty the FIFO, set id_valid=0 and id_inst=0, and block accept; flush has priority over stall[1].
REQ-024 SHALL, on flush during WAIT without mem_ack, enter DROP, keep mem_req asserted until mem_ack, discard that data, and then return to IDLE.
REQ-025 SHALL ignore mem_ack while in IDLE.
REQ-026 SHALL have a minimum latency of 2 edges from pc_i accept to id_valid=1 (accept, ack, pop), with zero-wait memory.

Reset
REQ-027 SHALL, with rst=1 at an edge, set state=IDLE, FIFO empty, mem_req=0, mem_addr=0, id_pc=0, id_inst=0, and id_valid=0.
REQ-028 SHALL, when reset occurs mid-request, abandon the request: mem_req=0 from the next cycle, and late acks are ignored per REQ-025.
REQ-029 SHALL hold fetch_stall_req=0 while ce_i=0, which covers the post-reset cycle of the PC register.

Configuration
REQ-030 SHALL support macro IFB_BYPASS_EN: when defined, a response arriving with the FIFO empty, stall[1]=0 and flush=0 is loaded directly into id_pc/id_inst on the ack edge, with no push; minimum latency becomes 1 edge.
REQ-031 SHALL, when IFB_BYPASS_EN is undefined, route every response through the FIFO as in REQ-019 and REQ-020.

Verification
REQ-032 SHALL pass: rst for 2 cycles, then ce_i=1, pc_i=0x0, zero-wait ack -> mem_req=1 with mem_addr=0x0 one cycle later; id_valid=1 with id_pc=0x0 two edges after accept (one edge with IFB_BYPASS_EN).
REQ-033 SHALL pass: stall[1]=1 for 4 cycles with continuous fetch -> FIFO fills to 2, fetch_stall_req=1, and no mem_req while full; after release, instructions at 0x4 and 0x8 issue in order with no duplicates.
REQ-034 SHALL pass: flush while WAIT at 0x10 with ack delayed 3 cycles -> DROP state; data 0xDEADBEEF never appears on id_inst; IDLE on the ack edge.
REQ-035 SHALL pass: rst asserted while mem_req=1 -> mem_req=0 next cycle; all outputs zero; a stray mem_ack causes no push.
REQ-036 SHALL pass: ack on the same cycle as a new accept, with FIFO occupancy 1 and stall[1]=0 -> back-to-back mem_req with no idle cycle; mem_addr steps 0x20 to 0x24.

Source files
------------

// File: rtl/inst_fetch_buf.sv
// -----------------------------------------------------------------------------
// inst_fetch_buf
//   Instruction fetch buffer between the PC register and the ID stage. It
//   issues one outstanding instruction-memory request at a time, queues
//   responses in a 2-entry FIFO, and presents one instruction per cycle to
//   the ID stage through registered outputs. When it cannot take a new fetch
//   address it raises fetch_stall_req so the control unit freezes the PC.
//
//   Optional build macro:
//     IFB_BYPASS_EN - a response that arrives while the FIFO is empty and
//                     the ID side is free goes straight to id_pc/id_inst on
//                     the ack edge, cutting the minimum latency to 1 edge.
//
// Ports
//   clk             in   rising-edge clock
//   rst             in   synchronous, active-high reset
//   pc_i[31:0]      in   fetch address from the PC register
//   ce_i            in   PC register chip enable (0 = no fetch wanted)
//   stall[5:0]      in   pipeline stall vector; stall[1] holds the ID outputs
//   flush           in   discard all buffered and in-flight instructions
//   mem_req         out  instruction memory request, held until mem_ack
//   mem_addr[31:0]  out  request address, stable while mem_req=1
//   mem_ack         in   memory response strobe (data valid same cycle)
//   mem_rdata[31:0] in   instruction word
//   id_pc[31:0]     out  registered PC to ID
//   id_inst[31:0]   out  registered instruction to ID
//   id_valid        out  id_pc/id_inst hold a real instruction
//   fetch_stall_req out  combinational request to freeze the PC (stall[0])
// -----------------------------------------------------------------------------
module inst_fetch_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        ce_i,
  input  logic [5:0]  stall,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid,
  output logic        fetch_stall_req
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // nothing outstanding
    S_WAIT = 2'd1,  // request outstanding, data wanted
    S_DROP = 2'd2   // request outstanding, data to be discarded
  } state_t;

  state_t state, state_next;

  // 2-entry FIFO of {pc, inst}
  logic [31:0] fifo_pc   [2];
  logic [31:0] fifo_inst [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;
  logic [1:0]  count_next;

  logic ack_wait;     // response for a live request this cycle
  logic id_advance;   // ID registers take a new value this edge
  logic bypass;       // response goes straight to the ID registers
  logic push;
  logic pop;
  logic free_after;   // no request left outstanding after this cycle
  logic accept;

  assign ack_wait   = (state == S_WAIT) && mem_ack;
  assign id_advance = ~flush & ~stall[1];

`ifdef IFB_BYPASS_EN
  assign bypass = ack_wait & id_advance & (count == 2'd0);
`else
  assign bypass = 1'b0;
`endif

  // A response that coincides with flush is in-flight data and is discarded.
  assign push = ack_wait & ~flush & ~bypass;
  assign pop  = id_advance & (count != 2'd0);

  assign count_next = count + {1'b0, push} - {1'b0, pop};

  // A new fetch is only taken if there is room for its eventual response
  // even if ID stays stalled: at most one entry may be occupied after this
  // cycle's push/pop.
  assign free_after = (state == S_IDLE) | ack_wait;
  assign accept     = ce_i & ~flush & free_after & (count_next <= 2'd1);

  assign fetch_stall_req = ce_i & ~flush & ~accept;

  // Request is live in both WAIT and DROP; DROP must still see its ack.
  assign mem_req = (state != S_IDLE);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: state and all other registers use non-blocking assignments so every
  // flop samples the pre-edge values computed by the combinational logic.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (accept) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (mem_ack)    state_next = accept ? S_WAIT : S_IDLE;
        else if (flush) state_next = S_DROP;
      end
      S_DROP: begin
        if (mem_ack) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request address, FIFO control and ID registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
      id_pc    <= '0;
      id_inst  <= '0;
      id_valid <= 1'b0;
    end else begin
      if (accept) mem_addr <= pc_i;

      if (flush) begin
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
        count  <= 2'd0;
      end else begin
        if (pop)  rd_ptr <= ~rd_ptr;
        if (push) wr_ptr <= ~wr_ptr;
        count <= count_next;
      end

      if (flush) begin
        id_inst  <= '0;
        id_valid <= 1'b0;
      end else if (id_advance) begin
        if (bypass) begin
          id_pc    <= mem_addr;
          id_inst  <= mem_rdata;
          id_valid <= 1'b1;
        end else if (pop) begin
          // Reads the pre-edge head, so a same-edge push into a full FIFO
          // lands after the pop.
          id_pc    <= fifo_pc[rd_ptr];
          id_inst  <= fifo_inst[rd_ptr];
          id_valid <= 1'b1;
        end else begin
          id_inst  <= '0;
          id_valid <= 1'b0;
        end
      end
    end
  end

  // NOTE: FIFO storage is not reset; count/pointers alone define which
  // entries are meaningful, so the data array can map to plain storage.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]   <= mem_addr;
      fifo_inst[wr_ptr] <= mem_rdata;
    end
  end

endmodule
